// File: rtl/ami_mailbox.sv
// ami_mailbox: executes slot-store commands from the secure-boot FSM against an on-chip key/ID file.
// Optional macro AMI_MBOX_ZEROIZE_EN enables opcode 06 (sequential clear of every slot and lock bit).
module ami_mailbox #(
    parameter int unsigned NUM_SLOTS = 8,
    parameter int unsigned CMP_CHUNK = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [255:0]         fsm_ami,
    output logic [2:0]           ami_ack,
    output logic [255:0]         ami_out,
    output logic [NUM_SLOTS-1:0] locked_map,
    output logic [15:0]          cmd_count
);
    localparam int unsigned DATA_W    = 224;
    localparam int unsigned SLOT_W    = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam int unsigned CMP_STEPS = DATA_W / CMP_CHUNK;
`ifdef AMI_MBOX_ZEROIZE_EN
    localparam int unsigned MAX_STEPS = (NUM_SLOTS > CMP_STEPS) ? NUM_SLOTS : CMP_STEPS;
`else
    localparam int unsigned MAX_STEPS = CMP_STEPS;
`endif
    localparam int unsigned CNT_W     = $clog2(MAX_STEPS) + 1;
    localparam int unsigned SHIFT_W   = $clog2(DATA_W) + 1;

    localparam logic [2:0] ACK_IDLE  = 3'b000;
    localparam logic [2:0] ACK_BUSY  = 3'b001;
    localparam logic [2:0] ACK_OK    = 3'b010;
    localparam logic [2:0] ACK_RDATA = 3'b011;
    localparam logic [2:0] ACK_MATCH = 3'b100;
    localparam logic [2:0] ACK_MISM  = 3'b101;
    localparam logic [2:0] ACK_ERR   = 3'b110;

    localparam logic [7:0] OP_WRITE   = 8'h01;
    localparam logic [7:0] OP_READ    = 8'h02;
    localparam logic [7:0] OP_COMPARE = 8'h03;
    localparam logic [7:0] OP_LOCK    = 8'h04;
    localparam logic [7:0] OP_CLEAR   = 8'h05;
`ifdef AMI_MBOX_ZEROIZE_EN
    localparam logic [7:0] OP_ZEROIZE = 8'h06;
`endif

    localparam logic [DATA_W-1:0] CHUNK_MASK = {{(DATA_W-CMP_CHUNK){1'b0}}, {CMP_CHUNK{1'b1}}};

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t               state_q, state_d;
    logic [7:0]           op_q, op_d;
    logic [7:0]           slot_q, slot_d;
    logic [DATA_W-1:0]    payload_q, payload_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 mism_q, mism_d;
    logic [2:0]           ack_d;
    logic [255:0]         out_d;
    logic [NUM_SLOTS-1:0] locked_d;
    logic [15:0]          count_d;

    logic [DATA_W-1:0]    mem [NUM_SLOTS];
    logic                 mem_we;
    logic [SLOT_W-1:0]    mem_idx;
    logic [DATA_W-1:0]    mem_wdata;

    logic [SLOT_W-1:0]    sidx;
    logic [DATA_W-1:0]    slot_data;
    logic                 slot_oob;
    logic                 op_legal;
    logic                 uses_slot;
    logic                 cmd_err;
    logic [SHIFT_W-1:0]   shift_amt;
    logic                 chunk_mism;
    logic                 unused_rsvd;

    // Reserved command bits are never stored or decoded.
    assign unused_rsvd = ^fsm_ami[239:224];

    assign sidx      = slot_q[SLOT_W-1:0];
    assign slot_data = mem[sidx];
    assign slot_oob  = {1'b0, slot_q} >= 9'(NUM_SLOTS);

    // Opcode decode and first-EXEC-cycle error resolution.
    always_comb begin
        op_legal  = 1'b0;
        uses_slot = 1'b1;
        case (op_q)
            OP_WRITE, OP_READ, OP_COMPARE, OP_LOCK, OP_CLEAR: op_legal = 1'b1;
`ifdef AMI_MBOX_ZEROIZE_EN
            OP_ZEROIZE: begin
                op_legal  = 1'b1;
                uses_slot = 1'b0;
            end
`endif
            default: op_legal = 1'b0;
        endcase
    end

    assign cmd_err = !op_legal || (uses_slot && slot_oob) ||
                     (((op_q == OP_WRITE) || (op_q == OP_CLEAR)) && locked_map[sidx]);

    // Chunked compare: one CMP_CHUNK slice per EXEC cycle, LSB first.
    always_comb begin
        shift_amt  = SHIFT_W'(cnt_q) * SHIFT_W'(CMP_CHUNK);
        chunk_mism = |(((slot_data ^ payload_q) >> shift_amt) & CHUNK_MASK);
    end

    // Next-state and registered-output computation.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        slot_d    = slot_q;
        payload_d = payload_q;
        cnt_d     = cnt_q;
        mism_d    = mism_q;
        ack_d     = ami_ack;
        out_d     = ami_out;
        locked_d  = locked_map;
        count_d   = cmd_count;
        mem_we    = 1'b0;
        mem_idx   = sidx;
        mem_wdata = '0;
        case (state_q)
            IDLE: begin
                if (fsm_ami[255:248] != 8'h00) begin
                    op_d      = fsm_ami[255:248];
                    slot_d    = fsm_ami[247:240];
                    payload_d = fsm_ami[223:0];
                    cnt_d     = '0;
                    mism_d    = 1'b0;
                    ack_d     = ACK_BUSY;
                    out_d     = '0;
                    if (cmd_count != 16'hFFFF) count_d = cmd_count + 16'd1;
                    state_d   = EXEC;
                end
            end
            EXEC: begin
                state_d = RESP;
                ack_d   = ACK_OK;
                out_d   = '0;
                if (cmd_err) begin
                    ack_d = ACK_ERR;
                end else begin
                    case (op_q)
                        OP_WRITE: begin
                            mem_we    = 1'b1;
                            mem_wdata = payload_q;
                        end
                        OP_READ: begin
                            ack_d = ACK_RDATA;
                            out_d = {OP_READ, slot_q, 16'h0000, slot_data};
                        end
                        OP_LOCK:  locked_d[sidx] = 1'b1;
                        OP_CLEAR: mem_we = 1'b1;
                        OP_COMPARE: begin
                            // No early exit: latency is independent of where a mismatch sits.
                            mism_d = mism_q | chunk_mism;
                            if (cnt_q == CNT_W'(CMP_STEPS - 1)) begin
                                ack_d = mism_d ? ACK_MISM : ACK_MATCH;
                            end else begin
                                state_d = EXEC;
                                ack_d   = ACK_BUSY;
                                cnt_d   = cnt_q + CNT_W'(1);
                            end
                        end
`ifdef AMI_MBOX_ZEROIZE_EN
                        OP_ZEROIZE: begin
                            mem_we   = 1'b1;
                            mem_idx  = SLOT_W'(cnt_q);
                            locked_d[SLOT_W'(cnt_q)] = 1'b0;
                            if (cnt_q != CNT_W'(NUM_SLOTS - 1)) begin
                                state_d = EXEC;
                                ack_d   = ACK_BUSY;
                                cnt_d   = cnt_q + CNT_W'(1);
                            end
                        end
`endif
                        default: ack_d = ACK_ERR;
                    endcase
                end
            end
            RESP: begin
                if (fsm_ami[255:248] == 8'h00) begin
                    state_d = IDLE;
                    ack_d   = ACK_IDLE;
                    out_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            op_q       <= '0;
            slot_q     <= '0;
            payload_q  <= '0;
            cnt_q      <= '0;
            mism_q     <= 1'b0;
            ami_ack    <= ACK_IDLE;
            ami_out    <= '0;
            locked_map <= '0;
            cmd_count  <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            slot_q     <= slot_d;
            payload_q  <= payload_d;
            cnt_q      <= cnt_d;
            mism_q     <= mism_d;
            ami_ack    <= ack_d;
            ami_out    <= out_d;
            locked_map <= locked_d;
            cmd_count  <= count_d;
        end
    end

    // Slot storage; reset wipes key material even mid-command.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_SLOTS; i++) mem[i] <= '0;
        end else if (mem_we) begin
            mem[mem_idx] <= mem_wdata;
        end
    end
endmodule

// File: tb/tb_ami_mailbox.sv
// tb_ami_mailbox: directed commands with a response scoreboard for ami_mailbox.
// Honors AMI_MBOX_ZEROIZE_EN to select the expected opcode-06 behaviour.
module tb_ami_mailbox;
    localparam int unsigned NS = 8;

    localparam logic [2:0] ACK_IDLE  = 3'b000;
    localparam logic [2:0] ACK_BUSY  = 3'b001;
    localparam logic [2:0] ACK_OK    = 3'b010;
    localparam logic [2:0] ACK_RDATA = 3'b011;
    localparam logic [2:0] ACK_MATCH = 3'b100;
    localparam logic [2:0] ACK_MISM  = 3'b101;
    localparam logic [2:0] ACK_ERR   = 3'b110;

    localparam logic [223:0] A5  = {28{8'hA5}};
    localparam logic [223:0] P5  = {7{32'h1234_5678}};
    localparam logic [223:0] ZERO = 224'h0;

    logic          clk = 1'b0;
    logic          rst;
    logic [255:0]  fsm_ami;
    logic [2:0]    ami_ack;
    logic [255:0]  ami_out;
    logic [NS-1:0] locked_map;
    logic [15:0]   cmd_count;

    typedef struct {
        logic [2:0]   ack;
        logic [255:0] out;
        int           busy;
    } exp_t;

    exp_t        exp_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] exp_count = 16'h0;

    ami_mailbox #(.NUM_SLOTS(NS), .CMP_CHUNK(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .fsm_ami    (fsm_ami),
        .ami_ack    (ami_ack),
        .ami_out    (ami_out),
        .locked_map (locked_map),
        .cmd_count  (cmd_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] rd_word(input logic [7:0] slot, input logic [223:0] data);
        return {8'h02, slot, 16'h0000, data};
    endfunction

    // Monitor: a busy->final ack transition is one response; compare it to the oldest expectation.
    initial begin
        int         busy = 0;
        logic [2:0] prev = ACK_IDLE;
        forever begin
            @(negedge clk);
            if (ami_ack === ACK_BUSY) begin
                busy++;
            end else begin
                if (prev === ACK_BUSY && ami_ack !== ACK_IDLE) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_resp: got ack %b with no command pending", ami_ack);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        check("resp_ack", 256'(ami_ack), 256'(e.ack));
                        check("resp_out", ami_out, e.out);
                        check("resp_latency", 256'(busy), 256'(e.busy));
                    end
                end
                busy = 0;
            end
            prev = ami_ack;
        end
    end

    task automatic perturb_word();
        fsm_ami = {8'($urandom_range(1, 255)), 8'($urandom), 16'($urandom), {7{$urandom}}};
    endtask

    // Issue one command at a negedge, wait for its final code, hold, then drop the opcode.
    task automatic do_cmd(input logic [7:0] op, input logic [7:0] slot, input logic [223:0] pl,
                          input logic [2:0] eack, input logic [255:0] eout, input int ebusy,
                          input bit perturb);
        exp_t e;
        int   waited;
        int   hold;
        e.ack  = eack;
        e.out  = eout;
        e.busy = ebusy;
        exp_q.push_back(e);
        if (exp_count != 16'hFFFF) exp_count = exp_count + 16'd1;
        fsm_ami = {op, slot, 16'hBEEF, pl};
        @(negedge clk);
        waited = 0;
        while (ami_ack === ACK_BUSY && waited < 40) begin
            if (perturb) perturb_word();
            @(negedge clk);
            waited++;
        end
        if (waited >= 40) begin
            n_cmp++;
            n_bad++;
            $display("FAIL timeout: op %h still busy after %0d cycles", op, waited);
        end
        hold = perturb ? 20 : 1;
        for (int i = 0; i < hold; i++) begin
            if (perturb) perturb_word();
            @(negedge clk);
            check("hold_ack", 256'(ami_ack), 256'(eack));
            check("hold_out", ami_out, eout);
        end
        fsm_ami = {8'h00, fsm_ami[247:0]};
        @(negedge clk);
        check("drop_ack", 256'(ami_ack), 256'(ACK_IDLE));
        check("drop_out", ami_out, 256'h0);
        check("cmd_count", 256'(cmd_count), 256'(exp_count));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst     = 1'b1;
        fsm_ami = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("reset_ack", 256'(ami_ack), 256'(ACK_IDLE));
        check("reset_out", ami_out, 256'h0);
        check("reset_locked", 256'(locked_map), 256'h0);
        check("reset_count", 256'(cmd_count), 256'h0);

        // Write / read-back
        do_cmd(8'h01, 8'd3, A5, ACK_OK, 256'h0, 1, 1'b0);
        do_cmd(8'h02, 8'd3, ZERO, ACK_RDATA, rd_word(8'd3, A5), 1, 1'b0);

        // Compare match and MSB mismatch with identical latency
        do_cmd(8'h03, 8'd3, A5, ACK_MATCH, 256'h0, 7, 1'b0);
        do_cmd(8'h03, 8'd3, A5 ^ (224'd1 << 223), ACK_MISM, 256'h0, 7, 1'b0);

        // Clear path plus LSB-chunk mismatch on another slot
        do_cmd(8'h01, 8'd5, P5, ACK_OK, 256'h0, 1, 1'b0);
        do_cmd(8'h03, 8'd5, P5 ^ 224'd1, ACK_MISM, 256'h0, 7, 1'b0);
        do_cmd(8'h05, 8'd5, A5, ACK_OK, 256'h0, 1, 1'b0);
        do_cmd(8'h02, 8'd5, ZERO, ACK_RDATA, rd_word(8'd5, ZERO), 1, 1'b0);

        // Locking
        do_cmd(8'h04, 8'd3, ZERO, ACK_OK, 256'h0, 1, 1'b0);
        check("locked_map", 256'(locked_map), 256'h08);
        do_cmd(8'h01, 8'd3, ZERO, ACK_ERR, 256'h0, 1, 1'b0);
        do_cmd(8'h05, 8'd3, ZERO, ACK_ERR, 256'h0, 1, 1'b0);
        do_cmd(8'h02, 8'd3, ZERO, ACK_RDATA, rd_word(8'd3, A5), 1, 1'b0);
        do_cmd(8'h04, 8'd3, ZERO, ACK_OK, 256'h0, 1, 1'b0);
        check("locked_map_again", 256'(locked_map), 256'h08);

        // Illegal slot and opcode
        do_cmd(8'h02, 8'd8, ZERO, ACK_ERR, 256'h0, 1, 1'b0);
        do_cmd(8'h7F, 8'd0, ZERO, ACK_ERR, 256'h0, 1, 1'b0);

        // Hold-off: command word churns during EXEC and RESP; compare on a locked slot
        do_cmd(8'h03, 8'd3, A5, ACK_MATCH, 256'h0, 7, 1'b1);
        do_cmd(8'h02, 8'd3, ZERO, ACK_RDATA, rd_word(8'd3, A5), 1, 1'b1);

`ifdef AMI_MBOX_ZEROIZE_EN
        do_cmd(8'h06, 8'hFF, ZERO, ACK_OK, 256'h0, NS, 1'b0);
        check("zeroize_locked", 256'(locked_map), 256'h0);
        do_cmd(8'h02, 8'd3, ZERO, ACK_RDATA, rd_word(8'd3, ZERO), 1, 1'b0);
`else
        do_cmd(8'h06, 8'd3, ZERO, ACK_ERR, 256'h0, 1, 1'b0);
        check("op06_locked", 256'(locked_map), 256'h08);
        do_cmd(8'h02, 8'd3, ZERO, ACK_RDATA, rd_word(8'd3, A5), 1, 1'b0);
`endif

        // Reset during compare EXEC cycle 4
        fsm_ami = {8'h03, 8'd3, 16'h0000, A5};
        @(negedge clk);
        repeat (3) @(negedge clk);
        rst     = 1'b1;
        fsm_ami = '0;
        @(negedge clk);
        rst = 1'b0;
        exp_count = 16'h0;
        check("midrst_ack", 256'(ami_ack), 256'(ACK_IDLE));
        check("midrst_out", ami_out, 256'h0);
        check("midrst_locked", 256'(locked_map), 256'h0);
        check("midrst_count", 256'(cmd_count), 256'h0);
        for (int i = 0; i < int'(NS); i++) begin
            do_cmd(8'h02, 8'(i), ZERO, ACK_RDATA, rd_word(8'(i), ZERO), 1, 1'b0);
        end

        repeat (3) @(negedge clk);
        check("queue_empty", 256'(exp_q.size()), 256'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/ami_mailbox.md
Name: ami_mailbox

Overview:
- Downstream consumer of the secure-boot FSM's 256-bit command word (fsm_ami).
- Executes slot-store commands against a small on-chip key/ID register file.
- Returns a 3-bit status (ami_ack) and a 256-bit response word (ami_out) that feed straight back into the FSM.
- Transfer is a four-phase level handshake; no separate valid strobe.

Parameters:
- NUM_SLOTS, 8: number of 224-bit storage slots; power of 2, 2..256.
- CMP_CHUNK, 32: compare width per cycle; must divide 224.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- fsm_ami  input  256  command word: [255:248] opcode, [247:240] slot, [239:224] reserved (ignored), [223:0] payload
- ami_ack  output  3  status code
- ami_out  output  256  response word
- locked_map  output  NUM_SLOTS  bit i = slot i locked
- cmd_count  output  16  accepted-command counter, saturating

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=IDLE; ami_ack=000; ami_out=0; locked_map=0; cmd_count=0.
  - All slot data is zeroed, including when reset lands mid-command.
- Status codes:
  - 000 idle, 001 busy, 010 ok, 011 ok+read data, 100 match, 101 mismatch, 110 error, 111 unused.
- Opcodes:
  - 01 WRITE: slot <= payload.
  - 02 READ.
  - 03 COMPARE: payload vs slot.
  - 04 LOCK: idempotent.
  - 05 CLEAR: slot <= 0.
  - 06 ZEROIZE: see Optional Feature.
  - All other nonzero opcodes are illegal.
- States: IDLE -> EXEC -> RESP -> IDLE.
- IDLE:
  - A command is present when fsm_ami[255:248] != 0.
  - At edge T the whole word is latched, cmd_count increments (saturates at 16'hFFFF), and the block moves to EXEC.
  - ami_ack=001 from T+1.
- Later changes on fsm_ami are ignored until the block returns to IDLE.
- Error checks, all resolved in the first EXEC cycle:
  - slot >= NUM_SLOTS;
  - illegal opcode;
  - WRITE or CLEAR to a locked slot.
  - On error: EXEC lasts 1 cycle, no state change, ack=110 visible at T+2.
- WRITE / READ / LOCK / CLEAR: EXEC lasts 1 cycle; ack visible at T+2.
  - READ: ami_out = {8'h02, slot, 16'h0000, slot_data}; ack=011.
  - WRITE / LOCK / CLEAR: ack=010; ami_out=0.
- COMPARE:
  - EXEC lasts 224/CMP_CHUNK cycles (7 at default), scanning CMP_CHUNK bits per cycle from LSB.
  - Mismatches are OR-accumulated; no early exit, so timing is constant.
  - ack=100 or 101 visible at T+1+224/CMP_CHUNK (T+8 at default); ami_out=0.
  - COMPARE on a locked slot is permitted.
- RESP:
  - ami_ack and ami_out are held stable while fsm_ami[255:248] != 0.
  - When the opcode field is sampled as 0, the block enters IDLE; the next cycle ack=000 and ami_out=0.
- Back-to-back commands: a new opcode is accepted on the first IDLE edge, which requires the FSM to have dropped the opcode for at least 1 cycle.
- Slot data is 224 bits; bits [239:224] of fsm_ami are never stored.

Optional Feature:
- Macro: AMI_MBOX_ZEROIZE_EN.
- Defined:
  - Opcode 06 (slot field ignored) clears data and lock bit of every slot, one slot per EXEC cycle, slot 0 first.
  - EXEC lasts NUM_SLOTS cycles; ack=010 visible at T+1+NUM_SLOTS (T+9 at default).
  - Reset mid-zeroize behaves as a normal reset.
- Undefined:
  - Opcode 06 is illegal: ack=110 at T+2, no state change.
  - No zeroize counter logic is present.

Test Plan:
1. Reset, then WRITE slot 3 with payload 224'hA5..A5 (opcode 01). Expect ack 001 at T+1 and 010 at T+2; drop opcode -> ack 000 next cycle. Then READ slot 3: ack 011, ami_out = {8'h02, 8'h03, 16'h0, 224'hA5..A5}.
2. COMPARE slot 3 against A5..A5: ack 100 at T+8. Repeat with payload bit 223 flipped: ack 101 at T+8, identical latency.
3. LOCK slot 3 -> 010 and locked_map = 8'h08. WRITE slot 3 -> 110; READ still returns A5..A5. LOCK slot 3 again -> 010.
4. Illegal cases: slot 8 (out of range) -> 110 at T+2; opcode 7F -> 110 at T+2; cmd_count increments for each.
5. Hold-off: vary fsm_ami payload during EXEC and RESP. Response must be unaffected, and ack must stay at its final code for 20 cycles until the opcode drops to 0.
6. Assert rst during COMPARE EXEC cycle 4. Expect next cycle ack=000, locked_map=0, and a later READ of every slot returns data 0.
   - With AMI_MBOX_ZEROIZE_EN: opcode 06 -> ack 010 at T+9, and all slots and locks are cleared.
